// File: rtl/bot_update_hdlr_if.sv
// ---------------------------------------------------------------------------
// bot_update_hdlr_if
// Bundles the Rojobot system-register inputs and the event-FIFO outputs of
// bot_update_hdlr. The clock and reset stay plain ports on the module.
//
// Signals:
//   upd_sysregs         toggle flag, each edge is one update event
//   LocX/LocY/BotInfo/Sensors  8-bit Rojobot system registers
//   rd_en               pop the FIFO head (ignored when empty)
//   clr_ovf             clear the sticky overflow flag
//   evt_valid           FIFO non-empty
//   evt_data            FIFO head {BotInfo, Sensors, LocY, LocX}
//   evt_count           FIFO occupancy (FIFO_AW+1 bits)
//   overflow            sticky dropped-push flag
//   intr                registered copy of evt_valid
//   lap_cnt             signed sidescroller lap count (0 when the lap
//                       counter is not built)
//
// Modports: master = producer of the register/handshake inputs,
//           slave  = bot_update_hdlr itself.
// ---------------------------------------------------------------------------
interface bot_update_hdlr_if #(
  parameter int FIFO_AW = 2
) ();
  logic               upd_sysregs;
  logic [7:0]         LocX;
  logic [7:0]         LocY;
  logic [7:0]         BotInfo;
  logic [7:0]         Sensors;
  logic               rd_en;
  logic               clr_ovf;
  logic               evt_valid;
  logic [31:0]        evt_data;
  logic [FIFO_AW:0]   evt_count;
  logic               overflow;
  logic               intr;
  logic [7:0]         lap_cnt;

  modport master (
    output upd_sysregs, LocX, LocY, BotInfo, Sensors, rd_en, clr_ovf,
    input  evt_valid, evt_data, evt_count, overflow, intr, lap_cnt
  );

  modport slave (
    input  upd_sysregs, LocX, LocY, BotInfo, Sensors, rd_en, clr_ovf,
    output evt_valid, evt_data, evt_count, overflow, intr, lap_cnt
  );
endinterface

// File: rtl/bot_update_hdlr.sv
// ---------------------------------------------------------------------------
// bot_update_hdlr
// Watches the Rojobot upd_sysregs toggle flag. Every edge starts an event:
// wait SETTLE_CYC cycles for the registers to settle, snapshot
// {BotInfo, Sensors, LocY, LocX}, and push the snapshot into a small FIFO
// if it differs from the last one pushed. A level interrupt follows the
// FIFO non-empty flag one cycle later.
//
// Parameters:
//   SETTLE_CYC  cycles between toggle detection and snapshot (1..15)
//   FIFO_AW     FIFO address width, depth = 2**FIFO_AW
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    bot_update_hdlr_if.slave (register inputs, FIFO outputs)
//
// Optional feature: define BOT_LAP_CNT_EN to build the LocX wrap-around lap
// counter; otherwise lap_cnt is tied to zero.
// ---------------------------------------------------------------------------
module bot_update_hdlr #(
  parameter int SETTLE_CYC = 2,
  parameter int FIFO_AW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  bot_update_hdlr_if.slave    bus
);

  localparam int         DEPTH       = 2**FIFO_AW;
  localparam int         CW          = FIFO_AW + 1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PUSH} state_t;

  // ---------------------------------------------------------------- edge detect
  // meta_reg/s1_reg form the synchronizer; s2_reg holds the previous
  // synchronized level so any edge shows up as tgl for one cycle.
  logic meta_reg, s1_reg, s2_reg;
  logic tgl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
    end else begin
      meta_reg <= bus.upd_sysregs;
      s1_reg   <= meta_reg;
      s2_reg   <= s1_reg;
    end
  end

  assign tgl = s1_reg ^ s2_reg;

  // ---------------------------------------------------------------- FSM
  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       pend_reg, pend_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        // A pending toggle is consumed here, so pend always clears in IDLE.
        pend_next = 1'b0;
        if (tgl || pend_reg) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        pend_next = pend_reg | tgl;
        if (cnt_reg == 4'd0) begin
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      CAPTURE: begin
        pend_next  = pend_reg | tgl;
        state_next = PUSH;
      end
      PUSH: begin
        pend_next  = pend_reg | tgl;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- snapshot
  logic [31:0] snap_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_reg <= 32'd0;
    end else if (state_reg == CAPTURE) begin
      snap_reg <= {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX};
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, count_next, count_after_pop;
  logic [31:0]        head_reg;
  logic [31:0]        last_pushed_reg;
  logic               last_valid_reg;
  logic               overflow_reg, intr_reg;
  logic               full, push_req, push_ok, pop_ok, ovf_evt;

  assign full     = (count_reg == CW'(DEPTH));
  assign push_req = (state_reg == PUSH) &&
                    (!last_valid_reg || (snap_reg != last_pushed_reg));
  assign pop_ok   = bus.rd_en && (count_reg != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop_ok);
  assign ovf_evt  = push_req && full && !pop_ok;

  assign rd_ptr_next     = rd_ptr_reg + FIFO_AW'(pop_ok);
  assign count_after_pop = count_reg - CW'(pop_ok);
  assign count_next      = count_after_pop + CW'(push_ok);

  // Storage array without reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= snap_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      head_reg        <= 32'd0;
      last_pushed_reg <= 32'd0;
      last_valid_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
      intr_reg        <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg      <= wr_ptr_reg + FIFO_AW'(1);
        last_pushed_reg <= snap_reg;
        last_valid_reg  <= 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;

      // Head register: bypass the snapshot when it lands in an otherwise
      // empty FIFO; otherwise fetch the next entry only when one exists,
      // so never-written RAM locations are never presented.
      if (push_ok && (count_after_pop == '0)) begin
        head_reg <= snap_reg;
      end else if (pop_ok && (count_reg > CW'(1))) begin
        head_reg <= mem[rd_ptr_next];
      end

      // A drop in the same cycle as clr_ovf wins.
      if (ovf_evt) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_reg <= 1'b0;
      end

      intr_reg <= (count_reg != '0);
    end
  end

  assign bus.evt_valid = (count_reg != '0);
  assign bus.evt_data  = head_reg;
  assign bus.evt_count = count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.intr      = intr_reg;

  // ---------------------------------------------------------------- lap counter
`ifdef BOT_LAP_CNT_EN
  logic [7:0] lap_reg;
  logic       cap_seen_reg;

  // snap_reg still holds the previous capture while in CAPTURE, so its
  // low byte is the previous LocX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_reg      <= 8'd0;
      cap_seen_reg <= 1'b0;
    end else if (state_reg == CAPTURE) begin
      cap_seen_reg <= 1'b1;
      if (cap_seen_reg) begin
        if ((snap_reg[7:0] >= 8'h70) && (bus.LocX <= 8'h0F)) begin
          lap_reg <= lap_reg + 8'd1;
        end else if ((snap_reg[7:0] <= 8'h0F) && (bus.LocX >= 8'h70)) begin
          lap_reg <= lap_reg - 8'd1;
        end
      end
    end
  end

  assign bus.lap_cnt = lap_reg;
`else
  assign bus.lap_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bot_update_hdlr.sv
// ---------------------------------------------------------------------------
// tb_bot_update_hdlr
// Self-checking bench for bot_update_hdlr. An event-level reference model
// (queue of pushed snapshots, last-pushed value, sticky overflow, lap count)
// is updated once per completed event or pop and compared against the DUT
// outputs after everything has settled. Directed sequences cover latency,
// duplicate suppression, overflow, simultaneous push/pop, toggle merging and
// mid-event reset; a randomized phase mixes events, pops and clears.
// Build with +define+BOT_LAP_CNT_EN to exercise the lap counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bot_update_hdlr;
  localparam int SETTLE_CYC = 2;
  localparam int FIFO_AW    = 2;
  localparam int DEPTH      = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bot_update_hdlr_if #(.FIFO_AW(FIFO_AW)) bus ();

  bot_update_hdlr #(
    .SETTLE_CYC (SETTLE_CYC),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- model
  logic [31:0] q[$];
  logic [31:0] m_last;
  bit          m_last_v;
  bit          m_ovf;
  logic [7:0]  m_lap;
  logic [7:0]  m_prev_x;
  bit          m_cap_seen;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_last     = 32'd0;
    m_last_v   = 1'b0;
    m_ovf      = 1'b0;
    m_lap      = 8'd0;
    m_prev_x   = 8'd0;
    m_cap_seen = 1'b0;
  endfunction

  // One completed event: snapshot captured, optional pop in the push cycle
  // (applied first, it frees a slot), then push-or-drop.
  function automatic void model_event(input logic [31:0] vals, input bit pop,
                                      input bit clr);
    bit ovf_evt;
    if (m_cap_seen) begin
      if (m_prev_x >= 8'h70 && vals[7:0] <= 8'h0F)      m_lap = m_lap + 8'd1;
      else if (m_prev_x <= 8'h0F && vals[7:0] >= 8'h70) m_lap = m_lap - 8'd1;
    end
    m_cap_seen = 1'b1;
    m_prev_x   = vals[7:0];
    if (pop && q.size() != 0) void'(q.pop_front());
    ovf_evt = 1'b0;
    if (!m_last_v || vals != m_last) begin
      if (q.size() < DEPTH) begin
        q.push_back(vals);
        m_last   = vals;
        m_last_v = 1'b1;
      end else begin
        ovf_evt = 1'b1;
      end
    end
    if (ovf_evt)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] exp_lap;
`ifdef BOT_LAP_CNT_EN
    exp_lap = m_lap;
`else
    exp_lap = 8'h00;
`endif
    check_val({tag, ".count"}, 32'(bus.evt_count), 32'(q.size()));
    check_val({tag, ".valid"}, 32'(bus.evt_valid), 32'(q.size() != 0));
    check_val({tag, ".intr"},  32'(bus.intr),      32'(q.size() != 0));
    check_val({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    if (q.size() != 0) check_val({tag, ".data"}, bus.evt_data, q[0]);
    check_val({tag, ".lap"},   32'(bus.lap_cnt),   32'(exp_lap));
  endtask

  // ---------------------------------------------------------------- stimulus
  // Entered and left #1 after a rising edge. The toggle is sampled at the
  // next edge (cycle 1); the push cycle is cycle SETTLE_CYC+4.
  task automatic do_event(input logic [31:0] vals, input bit pop,
                          input bit clr, input bit chk_lat);
    {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = vals;
    bus.upd_sysregs = ~bus.upd_sysregs;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == SETTLE_CYC + 4) begin
        bus.rd_en   = pop;
        bus.clr_ovf = clr;
      end
      if (c == SETTLE_CYC + 5) begin
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
      end
      if (chk_lat) begin
        if (c == SETTLE_CYC + 4) check_val("lat.valid_early", 32'(bus.evt_valid), 32'd0);
        if (c == SETTLE_CYC + 5) begin
          check_val("lat.valid", 32'(bus.evt_valid), 32'd1);
          check_val("lat.intr_early", 32'(bus.intr), 32'd0);
          check_val("lat.data", bus.evt_data, vals);
          check_val("lat.count", 32'(bus.evt_count), 32'd1);
        end
        if (c == SETTLE_CYC + 6) check_val("lat.intr", 32'(bus.intr), 32'd1);
      end
    end
    model_event(vals, pop, clr);
    $display("[TB] event data=%08h pop=%0d clr=%0d count=%0d ovf=%0d lap=%0d",
             vals, pop, clr, bus.evt_count, bus.overflow, bus.lap_cnt);
    check_all("evt");
  endtask

  task automatic do_pop();
    bit was_v;
    was_v = (q.size() != 0);
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_val("pop.valid", 32'(bus.evt_valid), 32'(q.size() != 0));
    check_val("pop.intr_lag", 32'(bus.intr), 32'(was_v));
    if (q.size() != 0) check_val("pop.data", bus.evt_data, q[0]);
    @(posedge clk); #1;
    $display("[TB] pop count=%0d head=%08h", bus.evt_count, bus.evt_data);
    check_all("pop");
  endtask

  task automatic do_clr();
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    m_ovf = 1'b0;
    $display("[TB] clr_ovf ovf=%0d", bus.overflow);
    check_all("clr");
  endtask

  task automatic drain();
    while (q.size() != 0) do_pop();
  endtask

  function automatic logic [31:0] rand_vals();
    if (m_last_v && $urandom_range(0, 3) == 0) return m_last;
    return {8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, ".valid"}, 32'(bus.evt_valid), 32'd0);
    check_val({tag, ".data"},  bus.evt_data,       32'd0);
    check_val({tag, ".count"}, 32'(bus.evt_count), 32'd0);
    check_val({tag, ".ovf"},   32'(bus.overflow),  32'd0);
    check_val({tag, ".intr"},  32'(bus.intr),      32'd0);
    check_val({tag, ".lap"},   32'(bus.lap_cnt),   32'd0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    bus.upd_sysregs = 1'b0;
    {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = 32'd0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("rst_rel");

    // First event with latency checks, duplicate suppression, change push.
    do_event(32'h031F2010, 1'b0, 1'b0, 1'b1);
    do_event(32'h031F2010, 1'b0, 1'b0, 1'b0);
    check_val("dup.count", 32'(bus.evt_count), 32'd1);
    do_event(32'h031F2011, 1'b0, 1'b0, 1'b0);
    check_val("chg.count", 32'(bus.evt_count), 32'd2);

    // Fill to depth, then overflow with a fifth distinct value.
    do_event(32'h031F2012, 1'b0, 1'b0, 1'b0);
    do_event(32'h031F2013, 1'b0, 1'b0, 1'b0);
    do_event(32'h031F2014, 1'b0, 1'b0, 1'b0);
    check_val("full.count", 32'(bus.evt_count), 32'd4);
    check_val("full.ovf", 32'(bus.overflow), 32'd1);
    drain();
    do_clr();

    // Push with pop while empty, then push with pop while full.
    do_event(32'h031F2020, 1'b1, 1'b0, 1'b0);
    check_val("emptypp.count", 32'(bus.evt_count), 32'd1);
    do_event(32'h031F2021, 1'b0, 1'b0, 1'b0);
    do_event(32'h031F2022, 1'b0, 1'b0, 1'b0);
    do_event(32'h031F2023, 1'b0, 1'b0, 1'b0);
    do_event(32'h031F2024, 1'b1, 1'b0, 1'b0);
    check_val("fullpp.count", 32'(bus.evt_count), 32'd4);
    check_val("fullpp.ovf", 32'(bus.overflow), 32'd0);
    check_val("fullpp.head", bus.evt_data, 32'h031F2021);
    // Overflow coinciding with clr_ovf leaves the flag set.
    do_event(32'h031F2025, 1'b0, 1'b1, 1'b0);
    check_val("ovfclr.ovf", 32'(bus.overflow), 32'd1);
    drain();
    do_clr();

    // Three toggles on consecutive cycles -> one event plus one merged.
    a = m_last + 32'd1;
    b = m_last + 32'd2;
    c = m_last + 32'd3;
    {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = a;
    bus.upd_sysregs = ~bus.upd_sysregs;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k <= 2)  bus.upd_sysregs = ~bus.upd_sysregs;
      if (k == SETTLE_CYC + 4)  {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = b;
      if (k == 2*SETTLE_CYC + 7) {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = c;
    end
    model_event(a, 1'b0, 1'b0);
    model_event(b, 1'b0, 1'b0);
    $display("[TB] merge burst count=%0d", bus.evt_count);
    check_val("merge.count", 32'(bus.evt_count), 32'd2);
    check_all("merge");
    drain();

    // Randomized mix of events, pops and overflow clears.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      do_event(rand_vals(), ($urandom_range(0, 4) == 0),
                                ($urandom_range(0, 4) == 0), 1'b0);
      else if (r <= 8) do_pop();
      else             do_clr();
    end

    // Reset while the FSM is in SETTLE: everything clears, no push.
    {bus.BotInfo, bus.Sensors, bus.LocY, bus.LocX} = 32'h0A0B0C0D;
    bus.upd_sysregs = ~bus.upd_sysregs;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    bus.upd_sysregs = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (15) @(posedge clk);
    #1;
    $display("[TB] reset mid-event count=%0d", bus.evt_count);
    check_zero("rst_after");

    // Sidescroller wrap sequence for the lap counter.
    do_event(32'h0000007A, 1'b0, 1'b0, 1'b0);
    do_event(32'h00000001, 1'b0, 1'b0, 1'b0);
`ifdef BOT_LAP_CNT_EN
    check_val("lap.fwd", 32'(bus.lap_cnt), 32'd1);
`endif
    do_event(32'h0000007B, 1'b0, 1'b0, 1'b0);
`ifdef BOT_LAP_CNT_EN
    check_val("lap.back", 32'(bus.lap_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
